// File: rtl/imm_encoder_pkg.sv
// Shared types for the ARM immediate encoder: FSM states, field widths, operand layout.
// Pure declarations, no logic and no latency.
// Optional second MVN pass is selected by INV_SEARCH_EN in the top; nothing here depends on it.
package imm_pkg;

    localparam int ROT_W     = 4;
    localparam int IMM_W     = 8;
    localparam int ROT_STEPS = 2 ** ROT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Operand2 immediate field as it appears in the instruction word.
    typedef struct packed {
        logic [ROT_W-1:0] rot;
        logic [IMM_W-1:0] imm8;
    } operand_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result bundle between an encoder client (master) and imm_encoder (slave).
// No logic, zero latency.
// Request is a single-cycle start pulse; busy/done report progress, no other backpressure.
interface imm_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] imm12;
    logic        inv;

    modport master (output start, output value,
                    input  busy, input done, input valid, input imm12, input inv);
    modport slave  (input  start, input value,
                    output busy, output done, output valid, output imm12, output inv);
endinterface

// File: rtl/imm_rot_check.sv
// Rotates a word left by 2*rot and tests whether the result fits in the low byte.
// Purely combinational, zero latency.
// No handshake; evaluated every cycle by the search FSM.
module imm_rot_check
    import imm_pkg::*;
(
    input  logic [31:0]      data,
    input  logic [ROT_W-1:0] rot,
    output logic             fits,
    output logic [IMM_W-1:0] imm8
);

    logic [4:0]  sh;
    logic [31:0] cand;

    // ROL by an even amount; the right-shift half is suppressed at zero so no 32-bit shift occurs.
    always_comb begin
        sh   = {rot, 1'b0};
        cand = data << sh;
        if (sh != 5'd0) begin
            cand = cand | (data >> (6'd32 - {1'b0, sh}));
        end
        fits = (cand[31:IMM_W] == '0);
        imm8 = cand[IMM_W-1:0];
    end

endmodule

// File: rtl/imm_encoder.sv
// Searches rotations 0..15 (one per clock) for an ARM rotated-imm8 encoding of a 32-bit constant.
// Latency: done in cycle k+2 for a match at rotation k; 17 with no match (33 with INV_SEARCH_EN).
// start is only accepted in IDLE; requests during SEARCH/DONE are dropped, not queued.
module imm_encoder
    import imm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    imm_encoder_if.slave bus
);

    localparam logic [1:0]       ST_IDLE   = 2'(IDLE);
    localparam logic [1:0]       ST_SEARCH = 2'(SEARCH);
    localparam logic [1:0]       ST_DONE   = 2'(DONE);
    localparam logic [ROT_W-1:0] ROT_MAX   = ROT_W'(ROT_STEPS - 1);

    logic [1:0]       state_q, state_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic [31:0]      val_q, val_d;
    logic             valid_q, valid_d;
    operand_t         imm12_q, imm12_d;

    logic [31:0]      chk_data;
    logic             chk_fits;
    logic [IMM_W-1:0] chk_imm8;

`ifdef INV_SEARCH_EN
    logic             pass_q, pass_d;
    logic             inv_q, inv_d;
`endif

    // Second pass tests the complement so a constant can be emitted as MVN.
    always_comb begin
`ifdef INV_SEARCH_EN
        chk_data = pass_q ? ~val_q : val_q;
`else
        chk_data = val_q;
`endif
    end

    imm_rot_check u_rot_check (
        .data (chk_data),
        .rot  (rot_q),
        .fits (chk_fits),
        .imm8 (chk_imm8)
    );

    // Next-state logic: accept in IDLE, step the rotation in SEARCH, pulse done in DONE.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        val_d   = val_q;
        valid_d = valid_q;
        imm12_d = imm12_q;
`ifdef INV_SEARCH_EN
        pass_d  = pass_q;
        inv_d   = inv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    val_d   = bus.value;
                    rot_d   = '0;
                    valid_d = 1'b0;
                    imm12_d = '0;
`ifdef INV_SEARCH_EN
                    pass_d  = 1'b0;
                    inv_d   = 1'b0;
`endif
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (chk_fits) begin
                    imm12_d = '{rot: rot_q, imm8: chk_imm8};
                    valid_d = 1'b1;
`ifdef INV_SEARCH_EN
                    inv_d   = pass_q;
`endif
                    state_d = ST_DONE;
                end else if (rot_q == ROT_MAX) begin
`ifdef INV_SEARCH_EN
                    if (!pass_q) begin
                        pass_d = 1'b1;
                        rot_d  = '0;
                    end else begin
                        imm12_d = '0;
                        valid_d = 1'b0;
                        inv_d   = 1'b0;
                        state_d = ST_DONE;
                    end
`else
                    imm12_d = '0;
                    valid_d = 1'b0;
                    state_d = ST_DONE;
`endif
                end else begin
                    rot_d = rot_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rot_q   <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
            imm12_q <= '0;
`ifdef INV_SEARCH_EN
            pass_q  <= 1'b0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            imm12_q <= imm12_d;
`ifdef INV_SEARCH_EN
            pass_q  <= pass_d;
            inv_q   <= inv_d;
`endif
        end
    end

    assign bus.busy  = (state_q == ST_SEARCH);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.valid = valid_q;
    assign bus.imm12 = imm12_q;
`ifdef INV_SEARCH_EN
    assign bus.inv   = inv_q;
`else
    assign bus.inv   = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a brute-force encoding model and per-cycle output checking.
module tb_imm_encoder;

    logic clk = 1'b0;
    logic reset;
    imm_encoder_if bus();

    imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic rst_s = 1'b0;
    logic chk_en = 1'b0;

    // Expected transaction in flight and the held result registers.
    logic        inflight = 1'b0;
    int          e_start, e_lat;
    logic        e_valid, e_inv;
    logic [11:0] e_imm;
    logic        h_valid = 1'b0, h_inv = 1'b0;
    logic [11:0] h_imm = 12'h000;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_s  <= reset;
        chk_en <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        logic [63:0] d;
        d = {x, x} >> s;
        return d[31:0];
    endfunction

    // Model: exhaustive search over (rot, imm8) for value == ROR(imm8, 2*rot), smallest rot first.
    task automatic model(input logic [31:0] v, output logic vld, output logic [11:0] imm,
                         output logic iv, output int lat);
        vld = 1'b0; imm = 12'h000; iv = 1'b0; lat = 17;
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 256; i++)
                if (!vld && ror32(32'(i), 2 * r) == v) begin
                    vld = 1'b1; imm = {4'(r), 8'(i)}; lat = r + 2;
                end
`ifdef INV_SEARCH_EN
        if (!vld) begin
            lat = 33;
            for (int r = 0; r < 16; r++)
                for (int i = 0; i < 256; i++)
                    if (!vld && ror32(32'(i), 2 * r) == ~v) begin
                        vld = 1'b1; iv = 1'b1; imm = {4'(r), 8'(i)}; lat = r + 18;
                    end
        end
`endif
    endtask

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        int  rel;
        logic busy_e, done_e;
        if (chk_en) begin
            busy_e = 1'b0; done_e = 1'b0;
            if (rst_s) begin
                inflight = 1'b0;
                h_valid = 1'b0; h_inv = 1'b0; h_imm = 12'h000;
            end else if (inflight) begin
                rel = cyc - e_start;
                if (rel == 1) begin
                    h_valid = 1'b0; h_inv = 1'b0; h_imm = 12'h000;
                end
                if (rel >= 1 && rel < e_lat) busy_e = 1'b1;
                if (rel == e_lat) begin
                    done_e = 1'b1;
                    h_valid = e_valid; h_inv = e_inv; h_imm = e_imm;
                    inflight = 1'b0;
                end
            end
            chk("busy",  32'(bus.busy),  32'(busy_e));
            chk("done",  32'(bus.done),  32'(done_e));
            chk("valid", 32'(bus.valid), 32'(h_valid));
            chk("imm12", 32'(bus.imm12), 32'(h_imm));
            chk("inv",   32'(bus.inv),   32'(h_inv));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a start pulse and arm the model; caller is at #1 after a posedge.
    task automatic issue(input logic [31:0] v);
        model(v, e_valid, e_imm, e_inv, e_lat);
        e_start  = cyc;
        inflight = 1'b1;
        bus.value = v;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.value = ~v;
    endtask

    task automatic run_txn(input string nm, input logic [31:0] v, input logic [11:0] x_imm,
                           input logic x_vld, input logic x_inv, input int x_lat,
                           input logic poke_mid, input logic poke_done);
        logic mv, mi;
        logic [11:0] mimm;
        int ml;
        int t0;
        bit seen;
        model(v, mv, mimm, mi, ml);
        chk({nm, "_model_imm"}, 32'(mimm), 32'(x_imm));
        chk({nm, "_model_lat"}, 32'(ml), 32'(x_lat));
        t0 = cyc;
        issue(v);
        if (poke_mid) begin
            step(1);
            bus.value = 32'h000000AB;
            bus.start = 1'b1;
            step(1);
            bus.start = 1'b0;
        end
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (bus.done) seen = 1;
            else step(1);
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_lat"},   32'(cyc - t0), 32'(x_lat));
        chk({nm, "_imm12"}, 32'(bus.imm12), 32'(x_imm));
        chk({nm, "_valid"}, 32'(bus.valid), 32'(x_vld));
        chk({nm, "_inv"},   32'(bus.inv),   32'(x_inv));
        if (poke_done) begin
            bus.value = 32'h000000CD;
            bus.start = 1'b1;
        end
        step(1);
        bus.start = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.value = 32'h0;
        step(3);
        reset = 1'b0;
        step(2);

        run_txn("ff",    32'h000000FF, 12'h0FF, 1'b1, 1'b0, 2,  1'b0, 1'b0);
        run_txn("ff_hi", 32'hFF000000, 12'h4FF, 1'b1, 1'b0, 6,  1'b0, 1'b1);
        run_txn("wrap",  32'hF000000F, 12'h2FF, 1'b1, 1'b0, 4,  1'b0, 1'b0);
        run_txn("zero",  32'h00000000, 12'h000, 1'b1, 1'b0, 2,  1'b0, 1'b0);
        run_txn("r15",   32'h000003FC, 12'hFFF, 1'b1, 1'b0, 17, 1'b0, 1'b0);
`ifdef INV_SEARCH_EN
        run_txn("odd",   32'h00000102, 12'h000, 1'b0, 1'b0, 33, 1'b0, 1'b0);
        run_txn("mvn",   32'hFFFFFF00, 12'h0FF, 1'b1, 1'b1, 18, 1'b0, 1'b0);
`else
        run_txn("odd",   32'h00000102, 12'h000, 1'b0, 1'b0, 17, 1'b0, 1'b0);
        run_txn("mvn",   32'hFFFFFF00, 12'h000, 1'b0, 1'b0, 17, 1'b0, 1'b0);
`endif
        run_txn("ignore", 32'hFF000000, 12'h4FF, 1'b1, 1'b0, 6, 1'b1, 1'b1);

        // Reset in cycle 5 of a no-match search: no done, outputs zero, then a normal request.
        issue(32'h00000102);
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        step(20);
        run_txn("after_rst", 32'hF000000F, 12'h2FF, 1'b1, 1'b0, 4, 1'b0, 1'b0);

        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
